// File: rtl/bc_msg_pkg.sv
// Shared definitions for the broadcast-message hub: message field offsets,
// a packed-vector slice helper and the round-robin next-grant function.
package bc_msg_pkg;

    // Message field offsets: [31:0] data, [35:32] byte strobe, [W-1:36] addr.
    localparam int DATA_LSB = 0;
    localparam int STRB_LSB = 32;
    localparam int ADDR_LSB = 36;

    // Upper bounds that size the generic helpers below.
    localparam int BC_MAX_CORES = 32;
    localparam int BC_MAX_MSG_W = 128;
    localparam int BC_VEC_W     = BC_MAX_CORES * BC_MAX_MSG_W;

    // Returns slice i_idx of width i_w from a zero-extended packed vector.
    // The caller truncates the result to its real message width.
    function automatic logic [BC_MAX_MSG_W-1:0] bc_slice(
        input logic [BC_VEC_W-1:0] i_vec,
        input int unsigned         i_idx,
        input int unsigned         i_w
    );
        bc_slice = BC_MAX_MSG_W'(i_vec >> (i_idx * i_w));
    endfunction

    // First requester searching upward (mod i_n) from i_last+1.
    // The loop runs downward so the nearest hit is written last and wins.
    // With no requests the result is i_last.
    function automatic logic [4:0] bc_rr_next(
        input logic [31:0] i_req,
        input logic [4:0]  i_last,
        input int unsigned i_n
    );
        logic [4:0]  w_g;
        int unsigned w_idx;
        w_g = i_last;
        for (int unsigned k = BC_MAX_CORES; k >= 1; k--) begin
            if (k <= i_n) begin
                w_idx = (32'(i_last) + k) % i_n;
                if (i_req[5'(w_idx)]) begin
                    w_g = 5'(w_idx);
                end
            end
        end
        return w_g;
    endfunction

endpackage

// File: rtl/bc_msg_fifo.sv
// Per-core ingress FIFO: distributed-RAM storage, combinational head,
// registered count/full/empty. Ports: i_clk, i_rst_n, i_push, i_data,
// i_pop, o_head, o_full, o_empty.
module bc_msg_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 46
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_do_push;
    logic             w_do_pop;
    logic [AW:0]      w_count_nxt;

    // A full FIFO refuses the push even when it pops in the same cycle.
    assign w_do_push = i_push & ~r_full;
    assign w_do_pop  = i_pop & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage carries no reset; pointers and count define validity.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/bc_msg_hub.sv
// Broadcast-message hub: per-core ingress FIFOs, round-robin arbiter and a
// registered re-broadcast of one message per cycle to every core.
// Ports: sys_clk, sys_rst_n, core_msg/_valid/_ready (per-core ingress),
// bc_msg/_valid/_src (broadcast), bc_msg_count (messages since reset).
module bc_msg_hub
    import bc_msg_pkg::*;
#(
    parameter int CORE_COUNT     = 16,
    parameter int MSG_ADDR_WIDTH = 10,
    parameter int MSG_WIDTH      = 32 + 4 + MSG_ADDR_WIDTH,
    parameter int FIFO_DEPTH     = 4,
    parameter int CORE_ID_WIDTH  = $clog2(CORE_COUNT)
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_n,
    input  logic [CORE_COUNT*MSG_WIDTH-1:0] core_msg,
    input  logic [CORE_COUNT-1:0]           core_msg_valid,
    output logic [CORE_COUNT-1:0]           core_msg_ready,
    output logic [MSG_WIDTH-1:0]            bc_msg,
    output logic                            bc_msg_valid,
    output logic [CORE_ID_WIDTH-1:0]        bc_msg_src,
    output logic [31:0]                     bc_msg_count
);

    logic [BC_VEC_W-1:0]      w_msg_ext;
    logic [MSG_WIDTH-1:0]     w_head [CORE_COUNT];
    logic [CORE_COUNT-1:0]    w_full;
    logic [CORE_COUNT-1:0]    w_empty;
    logic [CORE_COUNT-1:0]    w_push;
    logic [CORE_COUNT-1:0]    w_pop;
    logic [CORE_COUNT-1:0]    w_req;
    logic                     w_any;
    logic [CORE_ID_WIDTH-1:0] w_grant;

    logic [CORE_ID_WIDTH-1:0] r_last;
    logic [MSG_WIDTH-1:0]     r_bc_msg;
    logic                     r_bc_valid;
    logic [CORE_ID_WIDTH-1:0] r_bc_src;
    logic [31:0]              r_bc_count;

    assign w_msg_ext = BC_VEC_W'(core_msg);

    for (genvar g = 0; g < CORE_COUNT; g++) begin : g_core
        // Ready comes from the registered full flag only.
        assign core_msg_ready[g] = ~w_full[g];
        assign w_push[g] = core_msg_valid[g] & ~w_full[g];
        assign w_pop[g]  = w_any & (w_grant == CORE_ID_WIDTH'(g));

        bc_msg_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (MSG_WIDTH)
        ) u_fifo (
            .i_clk   (sys_clk),
            .i_rst_n (sys_rst_n),
            .i_push  (w_push[g]),
            .i_data  (MSG_WIDTH'(bc_slice(w_msg_ext, g, MSG_WIDTH))),
            .i_pop   (w_pop[g]),
            .o_head  (w_head[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );
    end

    assign w_req   = ~w_empty;
    assign w_any   = |w_req;
    assign w_grant = CORE_ID_WIDTH'(
        bc_rr_next(32'(w_req), 5'(r_last), CORE_COUNT));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_last     <= CORE_ID_WIDTH'(CORE_COUNT - 1);
            r_bc_msg   <= '0;
            r_bc_valid <= 1'b0;
            r_bc_src   <= '0;
            r_bc_count <= '0;
        end else if (w_any) begin
            r_last     <= w_grant;
            r_bc_msg   <= w_head[w_grant];
            r_bc_valid <= 1'b1;
            r_bc_src   <= w_grant;
            r_bc_count <= r_bc_count + 32'd1;
        end else begin
            // Idle: message and source hold their last values.
            r_bc_valid <= 1'b0;
        end
    end

    assign bc_msg       = r_bc_msg;
    assign bc_msg_valid = r_bc_valid;
    assign bc_msg_src   = r_bc_src;
    assign bc_msg_count = r_bc_count;

endmodule

// File: tb/tb_bc_msg_hub.sv
// Self-checking bench for bc_msg_hub: per-core scoreboard queues filled on
// acceptance and drained when the hub broadcasts.
module tb_bc_msg_hub;

    localparam int NC = 4;
    localparam int AW = 10;
    localparam int MW = 32 + 4 + AW;
    localparam int FD = 4;
    localparam int IW = 2;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic [NC*MW-1:0] core_msg = '0;
    logic [NC-1:0]    core_msg_valid = '0;
    logic [NC-1:0]    core_msg_ready;
    logic [MW-1:0]    bc_msg;
    logic             bc_msg_valid;
    logic [IW-1:0]    bc_msg_src;
    logic [31:0]      bc_msg_count;

    bc_msg_hub #(
        .CORE_COUNT     (NC),
        .MSG_ADDR_WIDTH (AW),
        .FIFO_DEPTH     (FD)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .core_msg       (core_msg),
        .core_msg_valid (core_msg_valid),
        .core_msg_ready (core_msg_ready),
        .bc_msg         (bc_msg),
        .bc_msg_valid   (bc_msg_valid),
        .bc_msg_src     (bc_msg_src),
        .bc_msg_count   (bc_msg_count)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [MW-1:0] sb_q [NC][$];
    logic [31:0]   exp_cnt = '0;
    int            cyc = 0;
    int            src_log[$];
    int            cyc_log[$];
    logic [31:0]   cnt_log[$];
    logic [NC-1:0] acc = '0;
    int            rem[NC];
    int            seq[NC];
    bit            f2 = 0;
    bit            want_acc2 = 0;
    int            fp_seen = 0;
    bit            saw_nr1 = 0;

    function automatic logic [MW-1:0] mk(input int i, input int s);
        logic [31:0] d;
        d = 32'hA500_0000 ^ {8'(i), 24'(s * 7 + 1)};
        return {AW'(i * 37 + s), 4'(s + i + 1), d};
    endfunction

    function automatic bit sb_empty();
        bit e;
        e = 1;
        for (int i = 0; i < NC; i++) begin
            if (sb_q[i].size() != 0) e = 0;
        end
        return e;
    endfunction

    // Acceptance: valid && ready seen at the edge, pushed to the model.
    always @(posedge sys_clk) begin
        cyc++;
        acc = core_msg_valid & core_msg_ready & {NC{sys_rst_n}};
        for (int i = 0; i < NC; i++) begin
            if (acc[i]) sb_q[i].push_back(core_msg[i*MW +: MW]);
        end
        if (want_acc2) begin
            chk("fullpop_next_push", 64'(acc[2]), 64'd1);
            want_acc2 = 0;
        end
        f2 = sys_rst_n && core_msg_valid[2] && !core_msg_ready[2];
    end

    // Broadcast side: pop the originating core's queue and compare.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (!core_msg_ready[1]) saw_nr1 = 1;
            if (f2) begin
                if (bc_msg_valid && bc_msg_src == 2) begin
                    chk("fullpop_ready", 64'(core_msg_ready[2]), 64'd1);
                    want_acc2 = 1;
                    fp_seen++;
                end
                f2 = 0;
            end
            if (bc_msg_valid) begin
                src_log.push_back(int'(bc_msg_src));
                cyc_log.push_back(cyc);
                cnt_log.push_back(bc_msg_count);
                exp_cnt = exp_cnt + 32'd1;
                chk("bc_count", 64'(bc_msg_count), 64'(exp_cnt));
                chk("bc_expected", 64'(sb_q[bc_msg_src].size() != 0), 64'd1);
                if (sb_q[bc_msg_src].size() != 0) begin
                    chk("bc_msg", 64'(bc_msg),
                        64'(sb_q[bc_msg_src].pop_front()));
                end
            end
        end
    end

    task automatic stream(input int maxc);
        bit done;
        done = 0;
        for (int c = 0; c < maxc && !done; c++) begin
            @(negedge sys_clk);
            for (int i = 0; i < NC; i++) begin
                if (core_msg_valid[i] && acc[i]) begin
                    seq[i]++;
                    rem[i]--;
                end
                if (rem[i] > 0) begin
                    core_msg[i*MW +: MW] = mk(i, seq[i]);
                    core_msg_valid[i] = 1'b1;
                end else begin
                    core_msg_valid[i] = 1'b0;
                end
            end
            done = (core_msg_valid == '0) && sb_empty() && !bc_msg_valid;
        end
        chk("stream_done", 64'(done), 64'd1);
    endtask

    task automatic clear_logs();
        src_log.delete();
        cyc_log.delete();
        cnt_log.delete();
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        core_msg_valid = '0;
        for (int i = 0; i < NC; i++) begin
            sb_q[i].delete();
            rem[i] = 0;
        end
        exp_cnt = '0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NC; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        repeat (3) @(negedge sys_clk);
        chk("rst_valid", 64'(bc_msg_valid), 64'd0);
        chk("rst_msg", 64'(bc_msg), 64'd0);
        chk("rst_src", 64'(bc_msg_src), 64'd0);
        chk("rst_count", 64'(bc_msg_count), 64'd0);
        chk("rst_ready", 64'(core_msg_ready), 64'hF);
        sys_rst_n = 1'b1;

        // Single message from core 3.
        @(negedge sys_clk);
        core_msg[3*MW +: MW] = {AW'(10'h12), 4'hF, 32'hDEADBEEF};
        core_msg_valid[3] = 1'b1;
        chk("t1_ready", 64'(core_msg_ready[3]), 64'd1);
        @(negedge sys_clk);
        core_msg_valid[3] = 1'b0;
        chk("t1_no_bypass", 64'(bc_msg_valid), 64'd0);
        @(negedge sys_clk);
        chk("t1_valid", 64'(bc_msg_valid), 64'd1);
        chk("t1_data", 64'(bc_msg[31:0]), 64'hDEADBEEF);
        chk("t1_strb", 64'(bc_msg[35:32]), 64'hF);
        chk("t1_addr", 64'(bc_msg[MW-1:36]), 64'h12);
        chk("t1_src", 64'(bc_msg_src), 64'd3);
        chk("t1_count", 64'(bc_msg_count), 64'd1);
        @(negedge sys_clk);
        chk("t1_idle", 64'(bc_msg_valid), 64'd0);
        chk("t1_hold_src", 64'(bc_msg_src), 64'd3);

        // Four cores push on the same edge just after reset.
        do_reset();
        clear_logs();
        for (int i = 0; i < NC; i++) rem[i] = 1;
        stream(50);
        chk("t2_n", 64'(src_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < src_log.size(); k++) begin
            chk("t2_src", 64'(src_log[k]), 64'(k));
            if (k > 0) chk("t2_back2back", 64'(cyc_log[k] - cyc_log[k-1]), 64'd1);
        end
        @(negedge sys_clk);
        chk("t2_idle", 64'(bc_msg_valid), 64'd0);

        // Saturation: every core streams 10 messages.
        do_reset();
        clear_logs();
        saw_nr1 = 0;
        fp_seen = 0;
        for (int i = 0; i < NC; i++) rem[i] = 10;
        stream(400);
        chk("t3_n", 64'(src_log.size()), 64'd40);
        for (int k = 0; k < src_log.size(); k++) begin
            chk("t3_rr", 64'(src_log[k]), 64'(k % NC));
        end
        if (cyc_log.size() == 40)
            chk("t3_span", 64'(cyc_log[39] - cyc_log[0]), 64'd39);
        chk("t3_ready_drop", 64'(saw_nr1), 64'd1);
        chk("t3_fullpop_seen", 64'(fp_seen != 0), 64'd1);

        // Reset with messages in flight.
        do_reset();
        @(negedge sys_clk);
        for (int i = 0; i < NC; i++) begin
            core_msg[i*MW +: MW] = mk(i, 99);
        end
        core_msg_valid = '1;
        @(negedge sys_clk);
        core_msg_valid = '0;
        @(posedge sys_clk);
        #2;
        chk("t4_pre_valid", 64'(bc_msg_valid), 64'd1);
        sys_rst_n = 1'b0;
        #1;
        chk("t4_valid", 64'(bc_msg_valid), 64'd0);
        chk("t4_count", 64'(bc_msg_count), 64'd0);
        chk("t4_msg", 64'(bc_msg), 64'd0);
        chk("t4_ready", 64'(core_msg_ready), 64'hF);
        for (int i = 0; i < NC; i++) sb_q[i].delete();
        exp_cnt = '0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (5) begin
            @(negedge sys_clk);
            chk("t4_no_stale", 64'(bc_msg_valid), 64'd0);
        end
        chk("t4_ready_after", 64'(core_msg_ready), 64'hF);

        // Counter wrap.
        @(negedge sys_clk);
        force dut.r_bc_count = 32'hFFFF_FFFE;
        @(negedge sys_clk);
        release dut.r_bc_count;
        exp_cnt = 32'hFFFF_FFFE;
        @(negedge sys_clk);
        chk("t5_preset", 64'(bc_msg_count), 64'hFFFF_FFFE);
        clear_logs();
        rem[0] = 3;
        stream(50);
        chk("t5_n", 64'(cnt_log.size()), 64'd3);
        if (cnt_log.size() == 3) begin
            chk("t5_c0", 64'(cnt_log[0]), 64'hFFFF_FFFF);
            chk("t5_c1", 64'(cnt_log[1]), 64'h0);
            chk("t5_c2", 64'(cnt_log[2]), 64'h1);
        end

        repeat (2) @(negedge sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
